// File: rtl/sd_word_sched_if.sv
// Bundle of word-side, detector-side and result-side signals of sd_word_sched.
// master: the scheduler's view; slave: the environment's view (producer, detector, consumer).
// Ports: in_valid/in_data/in_ready (word in), det_rst/seq_out/det_in (detector),
//        res_valid/res_count/res_ready (result out), busy; res_ovf only with SD_SAT_FLAG_EN.
interface sd_word_sched_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             det_rst;
   logic             seq_out;
   logic             det_in;
   logic             res_valid;
   logic [CNT_W-1:0] res_count;
   logic             res_ready;
   logic             busy;
`ifdef SD_SAT_FLAG_EN
   logic             res_ovf;

   modport master (
      input  in_valid, in_data, det_in, res_ready,
      output in_ready, det_rst, seq_out, res_valid, res_count, busy, res_ovf
   );
   modport slave (
      output in_valid, in_data, det_in, res_ready,
      input  in_ready, det_rst, seq_out, res_valid, res_count, busy, res_ovf
   );
`else
   modport master (
      input  in_valid, in_data, det_in, res_ready,
      output in_ready, det_rst, seq_out, res_valid, res_count, busy
   );
   modport slave (
      output in_valid, in_data, det_in, res_ready,
      input  in_ready, det_rst, seq_out, res_valid, res_count, busy
   );
`endif
endinterface

// File: rtl/sd_word_sched.sv
// Purpose: feeds parallel words MSB-first into a serial 1011 detector and counts its hits.
// Latency: res_valid rises WIDTH+DET_LAT+1 cycles after the accept cycle; one word per WIDTH+DET_LAT+2.
// Backpressure: in_ready only in IDLE; RESULT holds until res_ready, no bypass to a new word.
// Ports: clk, rst_n (async, active-low), bus (sd_word_sched_if.master).
// Optional feature: define SD_SAT_FLAG_EN to add bus.res_ovf (increment lost to saturation).
module sd_word_sched #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 4,
   parameter int DET_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   sd_word_sched_if.master  bus
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DRN_W = (DET_LAT > 0) ? $clog2(DET_LAT + 1) : 1;
   localparam int POS_W = $clog2(WIDTH + DET_LAT + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DET_LAT > 0) ? DET_LAT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sh_q;
   logic [IDX_W-1:0] idx_q;
   logic [DRN_W-1:0] drn_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             in_ready_q;
   logic             seq_out_q;
   logic             res_valid_q;
   logic             busy_q;

   logic             accept;
   logic             in_win;
   logic             hit;
   logic [POS_W-1:0] pos;

   assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;

   // pos is the cycle's offset on the SHIFT+DRAIN timeline. The detector output
   // seen at offset p reflects the bit shifted out at offset p-DET_LAT, so the
   // window opens at DET_LAT and covers exactly WIDTH samples.
   always_comb begin
      pos = '0;
      if (state_q == SHIFT) begin
         pos = POS_W'(idx_q);
      end else if (state_q == DRAIN) begin
         pos = POS_W'(WIDTH) + POS_W'(drn_q);
      end
      in_win = ((state_q == SHIFT) || (state_q == DRAIN)) && (pos >= POS_W'(DET_LAT));
   end

   assign hit = in_win && bus.det_in;

   // Count is cleared on accept and saturates instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         idx_q       <= '0;
         drn_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         seq_out_q   <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            IDLE: begin
               seq_out_q  <= 1'b0;
               in_ready_q <= 1'b1;
               if (accept) begin
                  // MSB goes straight onto seq_out; the rest waits in sh_q.
                  seq_out_q  <= bus.in_data[WIDTH-1];
                  sh_q       <= {bus.in_data[WIDTH-2:0], 1'b0};
                  idx_q      <= '0;
                  drn_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               if (idx_q == IDX_LAST) begin
                  seq_out_q <= 1'b0;
                  if (DET_LAT > 0) begin
                     state_q <= DRAIN;
                  end else begin
                     res_valid_q <= 1'b1;
                     state_q     <= RESULT;
                  end
               end else begin
                  idx_q     <= idx_q + IDX_W'(1);
                  seq_out_q <= sh_q[WIDTH-1];
                  sh_q      <= {sh_q[WIDTH-2:0], 1'b0};
               end
            end
            DRAIN: begin
               seq_out_q <= 1'b0;
               if (drn_q == DRN_LAST) begin
                  res_valid_q <= 1'b1;
                  state_q     <= RESULT;
               end else begin
                  drn_q <= drn_q + DRN_W'(1);
               end
            end
            RESULT: begin
               seq_out_q <= 1'b0;
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef SD_SAT_FLAG_EN
   logic ovf_q;

   // Sticky for the word: any in-window hit arriving while the count is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if (hit && (cnt_q == CNT_MAX)) begin
         ovf_q <= 1'b1;
      end
   end

   assign bus.res_ovf = ovf_q;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.det_rst   = accept;
   assign bus.seq_out   = seq_out_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_count = cnt_q;
   assign bus.busy      = busy_q;

endmodule
